// File: rtl/coverfloat_vector_writer_if.sv
// Record-in / character-out bus of the covervector writer.
// The producer presents one operation record per in_valid/in_ready handshake;
// the sink pulls ASCII characters with out_valid/out_ready.
interface coverfloat_vector_writer_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  op;
    logic [7:0]   rm;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    logic [7:0]   operandFmt;
    logic [127:0] result;
    logic [7:0]   resultFmt;
    logic [7:0]   exceptionBits;
    logic         intermS;
    logic [31:0]  intermX;
    logic [191:0] intermM;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_char;
    logic         out_last;

    // Producer of records and consumer of characters (bench / surrounding system).
    modport master (
        output in_valid, op, rm, a, b, c, operandFmt, result, resultFmt,
               exceptionBits, intermS, intermX, intermM, out_ready,
        input  in_ready, out_valid, out_char, out_last
    );

    // The writer itself.
    modport slave (
        input  in_valid, op, rm, a, b, c, operandFmt, result, resultFmt,
               exceptionBits, intermS, intermX, intermM, out_ready,
        output in_ready, out_valid, out_char, out_last
    );
endinterface

// File: rtl/coverfloat_vector_writer.sv
// Packs a floating-point operation record into a covervector, queues it in a
// small record FIFO and streams it out as one line of lowercase hex ASCII
// terminated by a newline (out_last marks the newline).
module coverfloat_vector_writer #(
    parameter int VEC_W = 804,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    coverfloat_vector_writer_if.slave   bus,
    output logic [31:0]                 vector_count,
    output logic                        busy
);
    localparam int NDIG = VEC_W / 4;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW   = $clog2(NDIG);

    localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEX  = 2'd1;
    localparam logic [1:0] ST_NL   = 2'd2;

    // Map a nibble to its lowercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h57 + {4'h0, nib};
        end
        return ch;
    endfunction

    logic [VEC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic [31:0]      vector_count_q, vector_count_d;

    logic [VEC_W-1:0] rec_s;
    logic [VEC_W-1:0] head_s;
    logic [VEC_W-1:0] shifted_s;
    logic [3:0]       nib_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             hs_s;
    logic             out_valid_s;

    // The sign nibble is {3'b000, intermS}, so the mantissa stays nibble aligned.
    assign rec_s = {bus.op, bus.rm, bus.a, bus.b, bus.c, bus.operandFmt,
                    bus.result, bus.resultFmt, bus.exceptionBits, 3'b000,
                    bus.intermS, bus.intermX, bus.intermM};

    assign full_s      = (cnt_q == FULL_CNT);
    assign empty_s     = (cnt_q == {(AW + 1){1'b0}});
    // A pop in the same cycle does not open a slot: full means full.
    assign push_s      = bus.in_valid && !full_s;
    assign out_valid_s = (state_q == ST_HEX) || (state_q == ST_NL);
    assign hs_s        = out_valid_s && bus.out_ready;
    assign pop_s       = hs_s && (state_q == ST_NL);

    // Head entry and current digit; head and digit only move on a handshake,
    // so the character is stable during a stall.
    assign head_s    = mem_q[rd_ptr_q];
    assign shifted_s = head_s << {dig_q, 2'b00};
    assign nib_s     = shifted_s[VEC_W-1 -: 4];

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (pop_s && !push_s) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Serializer FSM: IDLE -> HEX (digits 0..NDIG-1) -> NL -> HEX or IDLE.
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_d = ST_HEX;
                    dig_d   = {DW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEX: begin
                if (hs_s) begin
                    if (dig_q == LAST_DIG) begin
                        state_d = ST_NL;
                    end else begin
                        dig_d = dig_q + DW'(1);
                    end
                end else begin
                    state_d = ST_HEX;
                end
            end
            ST_NL: begin
                // Occupancy after the pop (and any same-cycle push) decides
                // whether the next line follows without a bubble.
                if (hs_s) begin
                    dig_d = {DW{1'b0}};
                    if (cnt_d != {(AW + 1){1'b0}}) begin
                        state_d = ST_HEX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_NL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dig_d   = {DW{1'b0}};
            end
        endcase
    end

    // Completed-line counter, wrapping naturally at 2^32.
    always_comb begin
        if (pop_s) begin
            vector_count_d = vector_count_q + 32'd1;
        end else begin
            vector_count_d = vector_count_q;
        end
    end

    // Character decode from the registered state.
    always_comb begin
        bus.out_char = 8'h00;
        bus.out_last = 1'b0;
        case (state_q)
            ST_HEX: begin
                bus.out_char = hex_ascii(nib_s);
                bus.out_last = 1'b0;
            end
            ST_NL: begin
                bus.out_char = 8'h0A;
                bus.out_last = 1'b1;
            end
            default: begin
                bus.out_char = 8'h00;
                bus.out_last = 1'b0;
            end
        endcase
    end

    // Record storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rec_s;
        end
    end

    // Control state; reset discards any partial line and all queued records.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= {AW{1'b0}};
            rd_ptr_q       <= {AW{1'b0}};
            cnt_q          <= {(AW + 1){1'b0}};
            state_q        <= ST_IDLE;
            dig_q          <= {DW{1'b0}};
            vector_count_q <= 32'd0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            dig_q          <= dig_d;
            vector_count_q <= vector_count_d;
        end
    end

    assign bus.in_ready  = !full_s;
    assign bus.out_valid = out_valid_s;
    assign vector_count  = vector_count_q;
    assign busy          = !empty_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_coverfloat_vector_writer.sv
// Bench for coverfloat_vector_writer: expected characters come from formatting
// each accepted record as hex text; occupancy and line counts are tracked
// with plain integers and compared against the DUT every cycle.
module tb_coverfloat_vector_writer;
    localparam int VEC_W = 804;
    localparam int DEPTH = 2;
    localparam int LINE  = 202;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] vector_count;
    logic        busy;

    coverfloat_vector_writer_if bus();

    coverfloat_vector_writer #(.VEC_W(VEC_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .vector_count (vector_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    byte         exp_q[$];
    byte         got_q[$];
    byte         saved_q[$];
    int          pending = 0;
    int          pending_prev = 0;
    int          lines_done = 0;
    logic [31:0] vcount_exp = 32'd0;
    logic        last_acc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] pack_inputs();
        return {bus.op, bus.rm, bus.a, bus.b, bus.c, bus.operandFmt, bus.result,
                bus.resultFmt, bus.exceptionBits, 3'b000, bus.intermS,
                bus.intermX, bus.intermM};
    endfunction

    task automatic clear_rec();
        bus.op = 32'd0; bus.rm = 8'd0; bus.a = 128'd0; bus.b = 128'd0; bus.c = 128'd0;
        bus.operandFmt = 8'd0; bus.result = 128'd0; bus.resultFmt = 8'd0;
        bus.exceptionBits = 8'd0; bus.intermS = 1'b0; bus.intermX = 32'd0;
        bus.intermM = 192'd0;
    endtask

    task automatic rand_rec();
        bus.op = $urandom(); bus.rm = 8'($urandom());
        bus.a = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.b = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.c = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.operandFmt = 8'($urandom());
        bus.result = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.resultFmt = 8'($urandom()); bus.exceptionBits = 8'($urandom());
        bus.intermS = 1'($urandom()); bus.intermX = $urandom();
        bus.intermM = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // One clock cycle: compare at the falling edge, update the model at the
    // rising edge, then return 1 ns later so the caller can drive inputs.
    task automatic tick();
        logic             acc;
        logic             hs;
        byte              ch;
        logic [VEC_W-1:0] rec;
        string            s;
        byte              e;
        acc = 1'b0; hs = 1'b0; ch = 8'd0; rec = '0;
        @(negedge clk);
        if (rst_n) begin
            check("in_ready", 64'(bus.in_ready), 64'(pending < DEPTH));
            check("busy", 64'(busy), 64'(pending != 0));
            check("vector_count", 64'(vector_count), 64'(vcount_exp));
            check("out_valid", 64'(bus.out_valid), 64'((pending > 0) && (pending_prev > 0)));
            if (bus.out_valid) begin
                check("char_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("out_char", 64'(bus.out_char), 64'(exp_q[0]));
                    check("out_last", 64'(bus.out_last), 64'(exp_q[0] == 8'h0A));
                end
            end
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            ch  = bus.out_char;
            rec = pack_inputs();
        end
        @(posedge clk);
        last_acc = acc;
        if (rst_n) begin
            pending_prev = pending;
            if (acc) begin
                s = $sformatf("%h", rec);
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
                exp_q.push_back(8'h0A);
                pending++;
            end
            if (hs) begin
                got_q.push_back(ch);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e == 8'h0A) begin
                        pending--;
                        vcount_exp = vcount_exp + 32'd1;
                        lines_done++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic send(input string name, input int bound);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        last_acc = 1'b0;
        while (!last_acc && n < bound) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        check(name, 64'(last_acc), 64'd1);
    endtask

    task automatic wait_lines(input string name, input int target, input int bound);
        int n;
        n = 0;
        while (lines_done < target && n < bound) begin
            tick();
            n++;
        end
        check(name, 64'(lines_done), 64'(target));
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (pending != 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_idle", 64'(pending), 64'd0);
        tick();
    endtask

    initial begin
        int    mm;
        int    base;
        int    cyc;
        int    nacc;
        int    sent;
        int    n;
        string a_str;
        string op_str;
        a_str  = "fedcba9876543210fedcba9876543210";
        op_str = "01234567";
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        clear_rec();

        // Reset values while reset is asserted.
        #2;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_char", 64'(bus.out_char), 64'h00);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_vector_count", 64'(vector_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Test 1: op=1, intermS=1, all else zero, sink always ready.
        bus.out_ready = 1'b1;
        clear_rec();
        bus.op = 32'h0000_0001;
        bus.intermS = 1'b1;
        got_q.delete();
        send("t1_accept", 10);
        check("t1_latency_idle", 64'(bus.out_valid), 64'd0);
        tick();
        check("t1_latency_valid", 64'(bus.out_valid), 64'd1);
        check("t1_first_char", 64'(bus.out_char), 64'h30);
        wait_lines("t1_line", 1, 400);
        check("t1_len", 64'(got_q.size()), 64'(LINE));
        if (got_q.size() == LINE) begin
            mm = 0;
            for (int i = 0; i < 201; i++) begin
                if (got_q[i] != ((i == 7 || i == 144) ? 8'h31 : 8'h30)) mm++;
            end
            check("t1_digits", 64'(mm), 64'd0);
            check("t1_digit7", 64'(got_q[7]), 64'h31);
            check("t1_digit144", 64'(got_q[144]), 64'h31);
            check("t1_newline", 64'(got_q[201]), 64'h0A);
        end
        check("t1_count", 64'(vector_count), 64'd1);
        tick();
        check("t1_busy_after", 64'(busy), 64'd0);

        // Test 2: nibble mapping, then the same record under random stalls.
        clear_rec();
        bus.op = 32'h0123_4567;
        bus.a = 128'hfedcba9876543210fedcba9876543210;
        bus.intermM = 192'h0123456789abcdef;
        got_q.delete();
        send("t2_accept_ready", 10);
        wait_lines("t2_line_ready", 2, 400);
        saved_q = got_q;
        mm = 0;
        for (int i = 0; i < 32; i++) if (saved_q[10 + i] != a_str[i]) mm++;
        for (int i = 0; i < 8; i++) if (saved_q[i] != op_str[i]) mm++;
        check("t2_hex_mapping", 64'(mm), 64'd0);
        got_q.delete();
        send("t2_accept_stall", 10);
        n = 0;
        while (lines_done < 3 && n < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.out_ready = 1'b1;
        check("t2_line_stall", 64'(lines_done), 64'd3);
        mm = 0;
        if (got_q.size() != saved_q.size()) mm = 1000;
        else for (int i = 0; i < got_q.size(); i++) if (got_q[i] != saved_q[i]) mm++;
        check("t2_same_sequence", 64'(mm), 64'd0);

        // Test 3: three records against a stalled sink.
        wait_idle(500);
        bus.out_ready = 1'b0;
        base = lines_done;
        rand_rec();
        send("t3_accept1", 5);
        rand_rec();
        send("t3_accept2", 5);
        check("t3_full", 64'(bus.in_ready), 64'd0);
        rand_rec();
        bus.in_valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) nacc++;
        end
        check("t3_third_held", 64'(nacc), 64'd0);
        bus.out_ready = 1'b1;
        cyc = 0;
        while (!last_acc && cyc < 400) begin
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("t3_third_accepted", 64'(last_acc), 64'd1);
        check("t3_after_first_nl", 64'(lines_done - base), 64'd1);
        while (lines_done < base + 3 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("t3_no_bubble", 64'(cyc), 64'(3 * LINE));

        // Test 4: asynchronous reset at digit 50 of line 2.
        wait_idle(500);
        rand_rec();
        send("t4_accept1", 5);
        rand_rec();
        send("t4_accept2", 5);
        base = got_q.size();
        n = 0;
        while (got_q.size() < base + LINE + 50 && n < 600) begin
            tick();
            n++;
        end
        check("t4_reached_digit50", 64'(got_q.size() - base), 64'(LINE + 50));
        rst_n = 1'b0;
        #1;
        check("t4_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t4_rst_count", 64'(vector_count), 64'd0);
        check("t4_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("t4_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        got_q.delete();
        pending = 0;
        pending_prev = 0;
        vcount_exp = 32'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = lines_done;
        clear_rec();
        bus.op = 32'hdeadbeef;
        send("t4_accept_fresh", 5);
        wait_lines("t4_fresh_line", base + 1, 400);
        check("t4_fresh_len", 64'(got_q.size()), 64'(LINE));
        check("t4_fresh_first", 64'(got_q[0]), 64'h64);
        check("t4_count_one", 64'(vector_count), 64'd1);

        // Test 5: vector_count wraps to zero.
        wait_idle(500);
        force dut.vector_count_q = 32'hFFFF_FFFF;
        #1 release dut.vector_count_q;
        vcount_exp = 32'hFFFF_FFFF;
        base = lines_done;
        rand_rec();
        send("t5_accept", 5);
        wait_lines("t5_line", base + 1, 400);
        check("t5_wrap", 64'(vector_count), 64'd0);

        // Test 6: randomized records, gaps and sink stalls.
        wait_idle(500);
        base = lines_done;
        sent = 0;
        n = 0;
        while (sent < 40 && n < 40000) begin
            if (!bus.in_valid && $urandom_range(0, 3) == 0) begin
                rand_rec();
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) begin
                bus.in_valid = 1'b0;
                sent++;
            end
            n++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("t6_all_sent", 64'(sent), 64'd40);
        wait_lines("t6_all_lines", base + 40, 2000);
        wait_idle(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
